memctrl: RTL

MEMCTRL -- requirements
Module: memctrl

---
 rtl/memctrl_pkg.sv | 24 ++
 rtl/memctrl_arb.sv | 20 ++
 rtl/memctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/memctrl_pkg.sv
// Shared widths, the default I/O window base and the requester type used by
// the byte-serial memory controller and its arbiter.
package memctrl_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int LEN_W  = 3;

   localparam logic [ADDR_W-1:0] IO_BASE_DEFAULT = 32'h0003_0000;

   typedef enum logic {
      REQ_IC = 1'b0,
      REQ_DC = 1'b1
   } requester_t;

   // Any byte count other than 1 or 2 is a full word.
   function automatic logic [LEN_W-1:0] norm_len(input logic [LEN_W-1:0] len);
      case (len)
         3'd1, 3'd2: norm_len = len;
         default:    norm_len = 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/memctrl_arb.sv
// Two-requester round-robin grant: a lone requester wins, and on a tie the
// side that was not granted last time wins.
module memctrl_arb
   import memctrl_pkg::*;
(
   input  logic       ic_req,
   input  logic       dc_req,
   input  requester_t last_grant,
   output logic       grant_valid,
   output requester_t grant
);

   always_comb begin
      grant_valid = ic_req | dc_req;
      grant       = REQ_IC;
      if (dc_req && (!ic_req || last_grant == REQ_IC))
         grant = REQ_DC;
   end

endmodule

// File: rtl/memctrl.sv
// Byte-serial memory controller sharing one 8-bit RAM port between the
// instruction fetch path and the data load/store path.
module memctrl
   import memctrl_pkg::*;
#(
   parameter logic [ADDR_W-1:0] IO_BASE = IO_BASE_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              clr,
   input  logic              iIC_en,
   input  logic [ADDR_W-1:0] iIC_pc,
   output logic              oIC_done,
   output logic [DATA_W-1:0] oIC_dt,
   input  logic              iDC_en,
   input  logic              iDC_ls,
   input  logic [ADDR_W-1:0] iDC_pc,
   input  logic [DATA_W-1:0] iDC_dt,
   input  logic [LEN_W-1:0]  iDC_len,
   output logic              oDC_done,
   output logic [DATA_W-1:0] oDC_dt,
   input  logic [7:0]        mem_din,
   output logic [7:0]        mem_dout,
   output logic [ADDR_W-1:0] mem_a,
   output logic              mem_wr,
   input  logic              io_buffer_full
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

   state_t            state;
   requester_t        owner, last_grant, grant;
   logic              grant_valid;
   logic [ADDR_W-1:0] pc, next_addr;
   logic [DATA_W-1:0] dt, result, result_nxt;
   logic [LEN_W-1:0]  len, cnt;
   logic [1:0]        rd_sel, wr_sel;
   logic              wr_q, io_stall;

   memctrl_arb u_arb (
      .ic_req      (iIC_en),
      .dc_req      (iDC_en),
      .last_grant  (last_grant),
      .grant_valid (grant_valid),
      .grant       (grant)
   );

   // Synchronous RAM: the byte for address k shows up on mem_din one cycle
   // later, so when cnt=k+1 the incoming byte belongs in lane k.
   always_comb begin
      io_stall   = (pc >= IO_BASE) && io_buffer_full;
      rd_sel     = cnt[1:0] - 2'd1;
      wr_sel     = cnt[1:0] + 2'd1;
      next_addr  = pc + {29'd0, cnt} + 32'd1;
      result_nxt = result;
      if (cnt != 3'd0)
         result_nxt[{rd_sel, 3'b000} +: 8] = mem_din;
   end

   assign mem_wr = wr_q & rdy & ~io_stall;

   // Port outputs are registered alongside the state; with rdy low everything
   // holds and only the combinational write strobe is gated off.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         owner      <= REQ_IC;
         last_grant <= REQ_IC;
         pc         <= '0;
         dt         <= '0;
         len        <= '0;
         cnt        <= '0;
         result     <= '0;
         wr_q       <= 1'b0;
         mem_a      <= '0;
         mem_dout   <= '0;
         oIC_done   <= 1'b0;
         oDC_done   <= 1'b0;
         oIC_dt     <= '0;
         oDC_dt     <= '0;
      end else if (rdy) begin
         wr_q     <= 1'b0;
         mem_a    <= '0;
         mem_dout <= '0;
         oIC_done <= 1'b0;
         oDC_done <= 1'b0;
         oIC_dt   <= '0;
         oDC_dt   <= '0;
         case (state)
            IDLE: begin
               if (grant_valid && !clr) begin
                  owner      <= grant;
                  last_grant <= grant;
                  cnt        <= '0;
                  result     <= '0;
                  if (grant == REQ_DC) begin
                     pc    <= iDC_pc;
                     dt    <= iDC_dt;
                     len   <= norm_len(iDC_len);
                     mem_a <= iDC_pc;
                     if (iDC_ls) begin
                        mem_dout <= iDC_dt[7:0];
                        wr_q     <= 1'b1;
                        state    <= WRITE;
                     end else begin
                        state <= READ;
                     end
                  end else begin
                     pc    <= iIC_pc;
                     dt    <= '0;
                     len   <= 3'd4;
                     mem_a <= iIC_pc;
                     state <= READ;
                  end
               end
            end
            READ: begin
               if (clr) begin
                  state <= IDLE;
               end else begin
                  result <= result_nxt;
                  cnt    <= cnt + 3'd1;
                  if (cnt == len) begin
                     state <= DONE;
                     if (owner == REQ_DC) begin
                        oDC_done <= 1'b1;
                        oDC_dt   <= result_nxt;
                     end else begin
                        oIC_done <= 1'b1;
                        oIC_dt   <= result_nxt;
                     end
                  end else if (cnt + 3'd1 < len) begin
                     mem_a <= next_addr;
                  end
               end
            end
            WRITE: begin
               if (io_stall) begin
                  wr_q     <= 1'b1;
                  mem_a    <= mem_a;
                  mem_dout <= mem_dout;
               end else if (cnt == len - 3'd1) begin
                  state    <= DONE;
                  oDC_done <= 1'b1;
                  oDC_dt   <= result;
               end else begin
                  cnt      <= cnt + 3'd1;
                  wr_q     <= 1'b1;
                  mem_a    <= next_addr;
                  mem_dout <= dt[{wr_sel, 3'b000} +: 8];
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
